// File: rtl/systolic_feeder.sv
// Edge feeder for an NxN output-stationary MAC array: buffers one A and one B tile,
// then streams them diagonally skewed and zero-padded onto the west/north edges.
module systolic_feeder #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int K_MAX      = 8,
  localparam int LANE_W    = (N > 1) ? $clog2(N) : 1,
  localparam int K_W       = (K_MAX > 1) ? $clog2(K_MAX) : 1,
  localparam int KL_W      = $clog2(K_MAX + 1),
  localparam int T_W       = $clog2(K_MAX + N)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic                      wr_sel,
  input  logic [LANE_W-1:0]         wr_lane,
  input  logic [K_W-1:0]            wr_k,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [KL_W-1:0]           k_len,
  input  logic                      start,
  output logic [N*DATA_WIDTH-1:0]   a_edge,
  output logic [N*DATA_WIDTH-1:0]   b_edge,
  output logic                      busy,
  output logic                      done
);

  // state  | meaning
  // IDLE   | waiting for start, buffers writable
  // STREAM | step counter t walks 0 .. kl+N-2, edges carry skewed operands
  // DRAIN  | N cycles of zero edges, t counts down N-1 .. 0
  // NULL   | one dead cycle for a kl=0 start so done lands after edge 1
  // DONE   | done pulse, buffers writable, start ignored
  typedef enum logic [2:0] {
    S_IDLE, S_STREAM, S_DRAIN, S_NULL, S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [T_W-1:0]            t_q, t_d;
  logic [KL_W-1:0]           kl_q, kl_d;
  logic [N*DATA_WIDTH-1:0]   a_edge_q, a_edge_d;
  logic [N*DATA_WIDTH-1:0]   b_edge_q, b_edge_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic [DATA_WIDTH-1:0]     a_mem_q [N][K_MAX];
  logic [DATA_WIDTH-1:0]     a_mem_d [N][K_MAX];
  logic [DATA_WIDTH-1:0]     b_mem_q [K_MAX][N];
  logic [DATA_WIDTH-1:0]     b_mem_d [K_MAX][N];

  logic [KL_W-1:0]           kl_in;
  logic [T_W-1:0]            t_last;
  logic                      wr_ok;
  int                        d;

  assign kl_in  = (int'(k_len) > K_MAX) ? KL_W'(K_MAX) : k_len;
  assign t_last = T_W'(int'(kl_q) + N - 2);
  assign wr_ok  = wr_en && (state_q == S_IDLE || state_q == S_DONE) && (int'(wr_k) < K_MAX);

  always_comb begin
    // Edge values are computed from the post-write buffer so a write colliding
    // with start is already visible in step 0.
    a_mem_d = a_mem_q;
    b_mem_d = b_mem_q;
    if (wr_ok) begin
      if (wr_sel) b_mem_d[wr_k][wr_lane] = wr_data;
      else        a_mem_d[wr_lane][wr_k] = wr_data;
    end

    state_d = state_q;
    t_d     = t_q;
    kl_d    = kl_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          kl_d    = kl_in;
          t_d     = '0;
          state_d = (kl_in == '0) ? S_NULL : S_STREAM;
        end
      end
      S_STREAM: begin
        if (t_q == t_last) begin
          state_d = S_DRAIN;
          t_d     = T_W'(N - 1);
        end else begin
          t_d = t_q + T_W'(1);
        end
      end
      S_DRAIN: begin
        if (t_q == '0) state_d = S_DONE;
        else           t_d = t_q - T_W'(1);
      end
      S_NULL:  state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        t_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase

    a_edge_d = '0;
    b_edge_d = '0;
    d        = 0;
    if (state_d == S_STREAM) begin
      for (int i = 0; i < N; i++) begin
        d = int'(t_d) - i;
        if (d >= 0 && d < int'(kl_d)) begin
          a_edge_d[i*DATA_WIDTH +: DATA_WIDTH] = a_mem_d[LANE_W'(i)][K_W'(d)];
          b_edge_d[i*DATA_WIDTH +: DATA_WIDTH] = b_mem_d[K_W'(d)][LANE_W'(i)];
        end
      end
    end

    busy_d = (state_d == S_STREAM) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      t_q      <= '0;
      kl_q     <= '0;
      a_edge_q <= '0;
      b_edge_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      kl_q     <= kl_d;
      a_edge_q <= a_edge_d;
      b_edge_q <= b_edge_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Tile buffers survive reset so a reset run can be replayed.
  always_ff @(posedge clk) begin
    a_mem_q <= a_mem_d;
    b_mem_q <= b_mem_d;
  end

  assign a_edge = a_edge_q;
  assign b_edge = b_edge_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: table of per-edge expectations for a k_len=4
// run plus hand-written sequences for k_len=0, clamping, busy writes, reset and collision.
module tb_systolic_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic        wr_sel = 1'b0;
  logic [1:0]  wr_lane = '0;
  logic [2:0]  wr_k = '0;
  logic [7:0]  wr_data = '0;
  logic [3:0]  k_len = '0;
  logic        start = 1'b0;
  logic [31:0] a_edge;
  logic [31:0] b_edge;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  systolic_feeder #(.N(4), .DATA_WIDTH(8), .K_MAX(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_lane(wr_lane),
    .wr_k(wr_k), .wr_data(wr_data), .k_len(k_len), .start(start),
    .a_edge(a_edge), .b_edge(b_edge), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input int lane, input int k, input int data);
    wr_sel  = sel;
    wr_lane = 2'(lane);
    wr_k    = 3'(k);
    wr_data = 8'(data);
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  // k_len=4 run checked against the table; optional start/write poke while busy.
  task automatic run_table(input string tag, input bit inject);
    k_len = 4'd4;
    start = 1'b1;
    for (int e = 0; e < 13; e++) begin
      tick();
      if (e == 0) start = 1'b0;
      chk($sformatf("%s a e%0d", tag, e), a_edge, tbl[e].a);
      chk($sformatf("%s b e%0d", tag, e), b_edge, tbl[e].b);
      chk($sformatf("%s busy e%0d", tag, e), 32'(busy), 32'(tbl[e].busy));
      chk($sformatf("%s done e%0d", tag, e), 32'(done), 32'(tbl[e].done));
      if (inject && e == 2) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_lane = 2'd0; wr_k = 3'd0; wr_data = 8'hFF;
      end
      if (inject && e == 3) begin
        start = 1'b0; wr_en = 1'b0;
      end
    end
  endtask

  initial begin
    logic seen_done;
    tbl[0]  = '{32'h00000001, 32'h00000001, 1'b1, 1'b0};
    tbl[1]  = '{32'h00001102, 32'h00000211, 1'b1, 1'b0};
    tbl[2]  = '{32'h00211203, 32'h00031221, 1'b1, 1'b0};
    tbl[3]  = '{32'h31221304, 32'h04132231, 1'b1, 1'b0};
    tbl[4]  = '{32'h32231400, 32'h14233200, 1'b1, 1'b0};
    tbl[5]  = '{32'h33240000, 32'h24330000, 1'b1, 1'b0};
    tbl[6]  = '{32'h34000000, 32'h34000000, 1'b1, 1'b0};
    tbl[7]  = '{32'h0, 32'h0, 1'b1, 1'b0};
    tbl[8]  = '{32'h0, 32'h0, 1'b1, 1'b0};
    tbl[9]  = '{32'h0, 32'h0, 1'b1, 1'b0};
    tbl[10] = '{32'h0, 32'h0, 1'b1, 1'b0};
    tbl[11] = '{32'h0, 32'h0, 1'b0, 1'b1};
    tbl[12] = '{32'h0, 32'h0, 1'b0, 1'b0};

    #1 reset = 1'b1;
    #2;
    chk("rst a_edge", a_edge, 32'h0);
    chk("rst b_edge", b_edge, 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst done", 32'(done), 32'h0);
    tick(); tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 8; k++) wr(1'b0, i, k, 16*i + k + 1);
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 4; j++) wr(1'b1, j, k, 16*k + j + 1);

    // k_len = 0
    k_len = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("kl0 busy e0", 32'(busy), 32'h0);
    chk("kl0 done e0", 32'(done), 32'h0);
    chk("kl0 a e0", a_edge, 32'h0);
    tick();
    chk("kl0 done e1", 32'(done), 32'h1);
    chk("kl0 busy e1", 32'(busy), 32'h0);
    chk("kl0 b e1", b_edge, 32'h0);
    tick();
    chk("kl0 done e2", 32'(done), 32'h0);
    tick();

    run_table("main", 1'b0);
    tick();

    run_table("busypoke", 1'b1);
    tick();
    // kl=1 run: lane0 must still show the original A[0][0]
    k_len = 4'd1;
    start = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      tick();
      if (e == 0) begin
        start = 1'b0;
        chk("keep A00 a e0", a_edge, 32'h00000001);
      end
      if (e == 3) chk("kl1 a e3", a_edge, 32'h31000000);
      if (e == 7) chk("kl1 done e7", 32'(done), 32'h0);
      if (e == 8) chk("kl1 done e8", 32'(done), 32'h1);
      if (e == 9) chk("kl1 done e9", 32'(done), 32'h0);
    end

    // k_len = 12 clamps to 8; later k_len change must not matter
    k_len = 4'd12;
    start = 1'b1;
    for (int e = 0; e <= 16; e++) begin
      tick();
      if (e == 0) begin
        start = 1'b0;
        k_len = 4'd1;
      end
      if (e == 7)  chk("clamp a e7", a_edge, 32'h35261708);
      if (e == 10) chk("clamp a e10", a_edge, 32'h38000000);
      if (e == 10) chk("clamp b e10", b_edge, 32'h74000000);
      if (e == 14) chk("clamp busy e14", 32'(busy), 32'h1);
      if (e == 14) chk("clamp done e14", 32'(done), 32'h0);
      if (e == 15) chk("clamp done e15", 32'(done), 32'h1);
      if (e == 15) chk("clamp busy e15", 32'(busy), 32'h0);
      if (e == 16) chk("clamp done e16", 32'(done), 32'h0);
    end

    // reset mid-run after edge 3
    k_len = 4'd4;
    start = 1'b1;
    for (int e = 0; e <= 3; e++) begin
      tick();
      if (e == 0) start = 1'b0;
    end
    chk("midrst a e3", a_edge, 32'h31221304);
    #1 reset = 1'b1;
    #1;
    chk("midrst a", a_edge, 32'h0);
    chk("midrst b", b_edge, 32'h0);
    chk("midrst busy", 32'(busy), 32'h0);
    tick();
    reset = 1'b0;
    seen_done = 1'b0;
    for (int e = 0; e < 14; e++) begin
      tick();
      if (done || busy) seen_done = 1'b1;
    end
    chk("midrst no done", 32'(seen_done), 32'h0);
    run_table("replay", 1'b0);
    tick();

    // write/start collision
    wr_en = 1'b1; wr_sel = 1'b0; wr_lane = 2'd0; wr_k = 3'd0; wr_data = 8'h5A;
    k_len = 4'd4;
    start = 1'b1;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    chk("collide a e0", a_edge, 32'h0000005A);
    chk("collide b e0", b_edge, 32'h00000001);
    for (int e = 1; e <= 12; e++) tick();
    chk("collide done end", 32'(done), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
